// File: rtl/bfs_serial.sv
// rtl/bfs_serial.sv - bit-serial full subtractor, LSB first, with streamed and parallel difference

// One-bit full-subtract cell: d = x - y - c, with borrow out
module bfs_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y ^ i_c;
    assign o_b = (~i_x & i_y) | (~(i_x ^ i_y) & i_c);
endmodule

module bfs_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             dbit,
    output logic             dvalid,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter value seen on the final SHIFT edge
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bo;

    // Current LSBs of the operand shift registers plus the stored borrow feed the cell
    bfs_cell u_cell (
        .i_x (r_a_sr[0]),
        .i_y (r_b_sr[0]),
        .i_c (r_borrow),
        .o_d (w_d),
        .o_b (w_bo)
    );

    // Control FSM, operand/result shift registers and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            dbit     <= 1'b0;
            dvalid   <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done   <= 1'b0;
                    dvalid <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        diff     <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    dbit     <= w_d;
                    dvalid   <= 1'b1;
                    diff     <= {w_d, diff[WIDTH-1:1]};
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    // The last bit lands together with the done pulse, so diff is final when done=1
                    if (r_cnt == LAST_BIT) begin
                        bout    <= w_bo;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    dvalid  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
